// File: rtl/aes_dec_ctrl_if.sv
// Byte-pair input stream and 16-bit result stream of the AES decipher sequencer.
// A beat transfers on a rising clk edge where valid && ready; the source holds its payload and valid until then.
interface aes_dec_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_in;
    logic [7:0]  key_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dataout;

    modport slave (
        input  in_valid, data_in, key_in, out_ready,
        output in_ready, out_valid, dataout
    );

    modport master (
        output in_valid, data_in, key_in, out_ready,
        input  in_ready, out_valid, dataout
    );
endinterface

// File: rtl/aes_dec_ctrl.sv
// Sequencer in front of the AES-128 decipher datapath: loads 16 byte pairs, waits
// LATENCY cycles with operands held, snapshots the plaintext and emits eight 16-bit words.
module aes_dec_ctrl #(
    parameter int unsigned LATENCY = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_dec_ctrl_if.slave        io,
    output logic [127:0]         dec_data,
    output logic [127:0]         dec_key,
    input  logic [127:0]         dec_result,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    localparam logic [7:0] WAIT_INIT = 8'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [3:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic [2:0]    word_idx_q, word_idx_d;
    logic [2:0]    next_idx;
    logic [127:0]  data_q, data_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  result_q, result_d;
    logic [15:0]   dataout_q, dataout_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            byte_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            word_idx_q  <= '0;
            data_q      <= '0;
            key_q       <= '0;
            result_q    <= '0;
            dataout_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            word_idx_q  <= word_idx_d;
            data_q      <= data_d;
            key_q       <= key_d;
            result_q    <= result_d;
            dataout_q   <= dataout_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        word_idx_d  = word_idx_q;
        data_d      = data_q;
        key_d       = key_q;
        result_d    = result_q;
        dataout_d   = dataout_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        next_idx    = word_idx_q + 3'd1;

        case (state_q)
            S_LOAD: begin
                // in_ready is 1 throughout LOAD, so in_valid alone marks a beat
                if (io.in_valid) begin
                    data_d     = {data_q[119:0], io.data_in};
                    key_d      = {key_q[119:0], io.key_in};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd15) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd0) begin
                    result_d    = dec_result;
                    word_idx_d  = 3'd0;
                    dataout_d   = dec_result[127:112];
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            S_OUT: begin
                if (io.out_ready) begin
                    if (word_idx_q == 3'd7) begin
                        state_d     = S_LOAD;
                        byte_cnt_d  = 4'd0;
                        word_idx_d  = 3'd0;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        word_idx_d = next_idx;
                        dataout_d  = result_q[127 - 16*next_idx -: 16];
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign io.in_ready  = (state_q == S_LOAD);
    assign io.out_valid = out_valid_q;
    assign io.dataout   = dataout_q;
    assign dec_data     = data_q;
    assign dec_key      = key_q;
    assign busy         = (state_q != S_LOAD);
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Scoreboard bench for aes_dec_ctrl with a stub decipher datapath.
// Driver pushes expected words per block; a negedge monitor pops and compares.
module tb_aes_dec_ctrl;

    localparam int LAT = 3;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] JUNK     = 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;

    logic         clk;
    logic         rst;
    logic [127:0] dec_data;
    logic [127:0] dec_key;
    logic [127:0] dec_result;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    aes_dec_ctrl_if io();

    aes_dec_ctrl #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (io),
        .dec_data   (dec_data),
        .dec_key    (dec_key),
        .dec_result (dec_result),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub datapath: the FIPS-197 vector decrypts to its known plaintext, anything
    // else to data^key. The output is corrupted while results stream out, so only
    // a proper snapshot at capture time yields the right words.
    function automatic logic [127:0] ref_dec(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
        return d ^ k;
    endfunction

    assign dec_result = ref_dec(dec_data, dec_key) ^ (io.out_valid ? JUNK : 128'd0);

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int mon_words = 0;
    int or_mode = 0;
    int stall_left = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic push_exp(input logic [127:0] d, input logic [127:0] k);
        logic [127:0] r;
        r = ref_dec(d, k);
        for (int i = 0; i < 8; i++) exp_q.push_back(r[127 - 16*i -: 16]);
    endtask

    // Monitor: done timing, latency from 16th beat, word order and hold under stall.
    initial begin
        int cyc;
        int beats;
        int beat_cyc;
        bit prev_ov;
        bit exp_done;
        cyc = 0; beats = 0; beat_cyc = 0; prev_ov = 0; exp_done = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                beats = 0; prev_ov = 0; exp_done = 0; mon_words = 0;
                exp_q.delete();
            end else begin
                chk("done", done, exp_done);
                if (exp_done) chk("in_ready_after_done", io.in_ready, 1);
                exp_done = 0;
                if (io.in_valid && io.in_ready) begin
                    beats++;
                    if (beats == 16) begin
                        beats = 0;
                        beat_cyc = cyc;
                    end
                end
                if (io.out_valid && !prev_ov) chk("latency", cyc - beat_cyc, LAT + 1);
                prev_ov = io.out_valid;
                if (io.out_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_word");
                    end else begin
                        chk("dataout", io.dataout, exp_q[0]);
                        if (io.out_ready) begin
                            void'(exp_q.pop_front());
                            mon_words++;
                            if (mon_words == 8) begin
                                mon_words = 0;
                                exp_done = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Downstream: always ready, random, or a 5-cycle stall on word 3.
    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: io.out_ready = 1'b1;
                1: io.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (stall_left > 0 && io.out_valid && mon_words == 3) begin
                        io.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        io.out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    // gaps: 0 = continuous, 1 = random, 2 = alternate 1/0
    task automatic send_block(input logic [127:0] d, input logic [127:0] k, input int gaps);
        int i;
        int guard;
        bit acc;
        bit tog;
        i = 0; guard = 0; tog = 1;
        push_exp(d, k);
        while (i < 16 && guard < 4000) begin
            if ((gaps == 1 && $urandom_range(0, 1) == 0) || (gaps == 2 && !tog)) begin
                io.in_valid = 1'b0;
            end else begin
                io.in_valid = 1'b1;
                io.data_in  = d[127 - 8*i -: 8];
                io.key_in   = k[127 - 8*i -: 8];
            end
            tog = !tog;
            acc = io.in_valid && io.in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) i++;
        end
        io.in_valid = 1'b0;
        if (i < 16) begin
            fail_now("load_timeout");
        end else begin
            chk("dec_data", dec_data, d);
            chk("dec_key", dec_key, k);
            chk("busy_after_load", busy, 1);
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 4000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 4000) fail_now("idle_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_dec_data", dec_data, 0);
        chk("rst_dec_key", dec_key, 0);
        chk("rst_busy", busy, 0);
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int g;
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.data_in  = '0;
        io.key_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_dataout", io.dataout, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, 0);

        // FIPS-197 vector, continuous
        or_mode = 0;
        send_block(FIPS_CT, FIPS_KEY, 0);
        wait_idle();

        // latency with data^key stub
        send_block(rand_blk(), rand_blk(), 0);
        wait_idle();

        // input stalls, alternating valid
        send_block(rand_blk(), rand_blk(), 2);
        wait_idle();

        // output backpressure on word 3 (6677)
        or_mode = 2;
        stall_left = 5;
        send_block(FIPS_CT, FIPS_KEY, 0);
        wait_idle();
        chk("stall_consumed", stall_left, 0);
        or_mode = 0;

        // reset during WAIT, then fresh load
        send_block(rand_blk(), rand_blk(), 0);
        do_reset();
        send_block(FIPS_CT, FIPS_KEY, 0);
        wait_idle();

        // reset at word 4 of OUT, then fresh load
        send_block(rand_blk(), rand_blk(), 0);
        g = 0;
        while (mon_words != 4 && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 1000) fail_now("word4_timeout");
        do_reset();
        send_block(rand_blk(), rand_blk(), 1);
        wait_idle();

        // back-to-back with in_valid held high
        send_block(FIPS_CT, FIPS_KEY, 0);
        send_block(rand_blk(), rand_blk(), 0);
        send_block(FIPS_CT, FIPS_KEY, 0);
        wait_idle();

        // randomized blocks under random backpressure
        or_mode = 1;
        for (int b = 0; b < 20; b++) begin
            send_block(rand_blk(), rand_blk(), int'($urandom_range(0, 2)));
        end
        wait_idle();
        or_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_dec_ctrl.md
Name: aes_dec_ctrl

Overview:
Sequencer that sits in front of the 128-bit AES decipher datapath. It collects a 16-byte ciphertext and a 16-byte key over an 8-bit valid/ready stream. It then holds both 128-bit operands stable for a fixed datapath settling time, captures the result, and returns it as eight 16-bit words over a valid/ready output stream. It replaces loose shift/load/output strobes with a single-clock synchronous control FSM.

Parameters:
LATENCY, 12, clock cycles from operands stable to dec_result valid (legal range 1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  data_in/key_in byte pair valid
in_ready  output  1  controller accepts a byte pair this cycle
data_in  input  8  ciphertext byte, MSB-first order
key_in  input  8  key byte, MSB-first order
dec_data  output  128  ciphertext operand to decipher datapath
dec_key  output  128  key operand to decipher datapath
dec_result  input  128  plaintext from decipher datapath
out_valid  output  1  dataout holds a valid word
out_ready  input  1  downstream accepts dataout
dataout  output  16  plaintext word, most significant word first
busy  output  1  high in WAIT and OUT
done  output  1  one-cycle pulse when the 8th word is accepted

Behaviour:
- Reset (rst=1 at clock edge, any state): state=LOAD, byte_cnt=0, wait_cnt=0, word_idx=0, dec_data=0, dec_key=0, result reg=0, dataout=0, out_valid=0, done=0. in_ready=1 from the first cycle after reset. Reset mid-operation discards all partial data.
- States: LOAD, WAIT, OUT.
- LOAD:
  - in_ready=1, busy=0, out_valid=0.
  - A beat is accepted when in_valid&in_ready. On each beat: dec_data <= {dec_data[119:0],data_in} and dec_key <= {dec_key[119:0],key_in}. byte_cnt increments mod 16.
  - The first accepted byte lands in bits [127:120] after the 16th beat.
  - On the 16th beat: go to WAIT and set wait_cnt=LATENCY-1.
  - in_valid=0 leaves everything unchanged.
- WAIT:
  - in_ready=0, busy=1.
  - dec_data and dec_key are held constant through WAIT and OUT.
  - wait_cnt decrements each cycle. In the cycle wait_cnt==0, capture result<=dec_result, set word_idx=0, and go to OUT.
  - The capture occurs exactly LATENCY cycles after the cycle in which the 16th beat is accepted.
- OUT:
  - out_valid=1, busy=1.
  - dataout = result[127-16*word_idx -: 16], driven from registers.
  - On out_valid&out_ready, word_idx increments.
  - If word_idx==7 on acceptance: done=1 for that following cycle, state=LOAD, byte_cnt=0, out_valid=0.
  - With out_ready=0, dataout and out_valid are held unchanged indefinitely.
- Inputs in non-LOAD states: in_valid is ignored outside LOAD (in_ready=0). out_ready is ignored outside OUT.
- Back-to-back operation: in_ready is 1 in the cycle immediately after the 8th word is accepted, so a new block can begin with zero bubble.
- Result snapshot: the captured result is independent of later dec_result changes.
- Counter widths: byte_cnt 4 bits, word_idx 3 bits, wait_cnt 8 bits. No overflow is possible within the legal LATENCY range.

Test Plan:
- FIPS-197 vector: stream ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with key 000102030405060708090a0b0c0d0e0f, continuous in_valid, out_ready=1, real decipher attached.
  - Required: dataout sequence 0011,2233,4455,6677,8899,aabb,ccdd,eeff, then done pulse.
- Latency check: stub datapath drives dec_result = dec_data ^ dec_key, LATENCY=3.
  - Required: out_valid rises exactly 4 cycles after the 16th beat (3 WAIT cycles + capture).
  - Required: word0 equals the upper 16 bits of data^key.
- Input stalls: in_valid toggled 1/0 every cycle.
  - Required: exactly 16 accepted beats, dec_data matches the 16 accepted bytes, with no duplicates and no skips.
- Output backpressure: out_ready=0 for 5 cycles on word 3, then 1.
  - Required: dataout stays 6677 while stalled.
  - Required: all 8 words are delivered in order, with done one cycle after eeff is accepted.
- Reset mid-operation: assert rst during WAIT and again at word 4 of OUT.
  - Required: next cycle out_valid=0, in_ready=1, dec_data=0.
  - Required: a fresh 16-byte load then decrypts correctly.
- Back-to-back blocks: two vectors streamed with in_valid held high.
  - Required: in_ready=1 in the cycle after the first done.
  - Required: the second output sequence is correct, and in_valid asserted during WAIT/OUT is ignored.
